// File: rtl/vproc_ctrl_pkg.sv
// Shared definitions for the vector control stage: opcodes, ALU codes,
// control-bundle layout and opcode classification helpers.
package vproc_ctrl_pkg;

  localparam int OP_W  = 5;
  localparam int ALU_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00001;
  localparam logic [OP_W-1:0] OP_MOVI = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_CMP  = 5'b01011;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'b01100;
  localparam logic [OP_W-1:0] OP_LW   = 5'b01101;
  localparam logic [OP_W-1:0] OP_SW   = 5'b01111;
  localparam logic [OP_W-1:0] OP_MOV  = 5'b10010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b10011;
  localparam logic [OP_W-1:0] OP_VADD = 5'b10100;
  localparam logic [OP_W-1:0] OP_VXOR = 5'b10101;
  localparam logic [OP_W-1:0] OP_VLW  = 5'b10110;
  localparam logic [OP_W-1:0] OP_VSW  = 5'b10111;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_MOV = 4'b1000;

  // Field order, MSB first, matches the classic single-cycle control bundle.
  typedef struct packed {
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [ALU_W-1:0]  alu_op;
  } ctrl_t;

  function automatic logic is_vector(input logic [OP_W-1:0] op);
    return op[4:2] == 3'b101;
  endfunction

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_VLW);
  endfunction

endpackage

// File: rtl/vector_control_sequencer_ctrl_decode.sv
// Combinational opcode decoder; vector opcodes reuse their scalar twin's
// controls, anything unlisted is flagged illegal with all controls low.
module ctrl_decode
  import vproc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output ctrl_t           ctrl_o,
  output logic            is_vector_o,
  output logic            illegal_o
);

  logic [OP_W-1:0] base_op;

  always_comb begin
    base_op = opcode_i;
    case (opcode_i)
      OP_VADD: base_op = OP_ADD;
      OP_VXOR: base_op = OP_XOR;
      OP_VLW:  base_op = OP_LW;
      OP_VSW:  base_op = OP_SW;
      default: ;
    endcase

    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (base_op)
      OP_ADD:  begin ctrl_o.reg_dst = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_ADD; end
      OP_ADDI: begin ctrl_o.alu_src = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_ADD; end
      OP_MOVI: begin ctrl_o.alu_src = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_MOV; end
      OP_MOV:  begin ctrl_o.reg_dst = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_MOV; end
      OP_XOR:  begin ctrl_o.reg_dst = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_XOR; end
      OP_BEQ:  begin ctrl_o.branch  = 1'b1; ctrl_o.alu_op = ALU_SUB; end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = is_load(opcode_i);
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = is_load(opcode_i);
        ctrl_o.alu_op     = ALU_ADD;
      end
      OP_SW:   begin ctrl_o.alu_src = 1'b1; ctrl_o.mem_write = 1'b1; ctrl_o.alu_op = ALU_ADD; end
      OP_CMP:  begin ctrl_o.reg_dst = 1'b1; ctrl_o.alu_op = ALU_SUB; end
      default: illegal_o = 1'b1;
    endcase
  end

  assign is_vector_o = is_vector(opcode_i);

endmodule

// File: rtl/vector_control_sequencer.sv
// Registered control stage: decodes one instruction per handshake, expands
// vector ops into LANES-wide beats, inserts load-use bubbles, honours flush.
module vector_control_sequencer
  import vproc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 5,
  parameter int VLEN     = 8,
  parameter int LANES    = 2,
  parameter int ALUOP_W  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [OPCODE_W-1:0]      opcode_i,
  input  logic [REG_W-1:0]         rs_i,
  input  logic [REG_W-1:0]         rt_i,
  input  logic [REG_W-1:0]         rd_i,
  input  logic                     flush_i,
  input  logic                     out_ready_i,
  output logic                     out_valid_o,
  output logic                     RegDst_o,
  output logic                     ALUSrc_o,
  output logic                     MemtoReg_o,
  output logic                     RegWrite_o,
  output logic                     MemRead_o,
  output logic                     MemWrite_o,
  output logic                     Branch_o,
  output logic                     Jump_o,
  output logic [ALUOP_W-1:0]       ALUOperation_o,
  output logic [REG_W-1:0]         out_wreg_o,
  output logic [$clog2(VLEN)-1:0]  elem_idx_o,
  output logic                     out_last_o,
  output logic                     err_illegal_o
);

  localparam int ELEM_W = $clog2(VLEN);
  localparam int NBEATS = VLEN / LANES;
  localparam logic [ELEM_W-1:0] LANE_STEP = ELEM_W'(LANES);
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(VLEN - LANES);

  if (VLEN % LANES != 0) begin : g_bad_lanes
    $error("VLEN must be a multiple of LANES");
  end
  if (OPCODE_W != OP_W || ALUOP_W != ALU_W) begin : g_bad_width
    $error("OPCODE_W/ALUOP_W must match vproc_ctrl_pkg");
  end

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q;
  ctrl_t              ctrl_q;
  logic [REG_W-1:0]   wreg_q;
  logic [ELEM_W-1:0]  elem_q, elem_d;
  logic               last_q, err_q;

  ctrl_t dec_ctrl;
  logic  dec_vec, dec_ill;
  logic  out_valid, consume, hazard, in_ready, accept;

  ctrl_decode u_decode (
    .opcode_i    (opcode_i),
    .ctrl_o      (dec_ctrl),
    .is_vector_o (dec_vec),
    .illegal_o   (dec_ill)
  );

  assign out_valid = (state_q == ISSUE);
  assign consume   = out_valid & out_ready_i;
  // Load result is not forwardable in the same cycle the load retires.
  assign hazard    = in_valid_i & consume & last_q & ctrl_q.mem_read & (wreg_q != '0)
                   & ((wreg_q == rs_i) | (wreg_q == rt_i));
  assign in_ready  = ~reset_i & ~flush_i & ~hazard & (~out_valid | (out_ready_i & last_q));
  assign accept    = in_valid_i & in_ready;
  assign elem_d    = elem_q + LANE_STEP;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      wreg_q  <= '0;
      elem_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      elem_q  <= '0;
    end else if (accept) begin
      state_q <= ISSUE;
      ctrl_q  <= dec_ctrl;
      wreg_q  <= dec_ctrl.reg_dst ? rd_i : rt_i;
      elem_q  <= '0;
      last_q  <= ~dec_vec | (NBEATS == 1);
      err_q   <= dec_ill;
    end else if (consume) begin
      if (last_q) begin
        state_q <= IDLE;
        elem_q  <= '0;
      end else begin
        elem_q <= elem_d;
        last_q <= (elem_d == LAST_ELEM);
      end
    end
  end

  assign in_ready_o     = in_ready;
  assign out_valid_o    = out_valid;
  assign RegDst_o       = ctrl_q.reg_dst;
  assign ALUSrc_o       = ctrl_q.alu_src;
  assign MemtoReg_o     = ctrl_q.mem_to_reg;
  assign RegWrite_o     = ctrl_q.reg_write;
  assign MemRead_o      = ctrl_q.mem_read;
  assign MemWrite_o     = ctrl_q.mem_write;
  assign Branch_o       = ctrl_q.branch;
  assign Jump_o         = ctrl_q.jump;
  assign ALUOperation_o = ctrl_q.alu_op;
  assign out_wreg_o     = wreg_q;
  assign elem_idx_o     = elem_q;
  assign out_last_o     = last_q;
  assign err_illegal_o  = err_q;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Randomized bench for vector_control_sequencer, checked every cycle against
// an instruction/beat-level reference model.
module tb_vector_control_sequencer;

  localparam int VLEN   = 8;
  localparam int LANES  = 2;
  localparam int NBEATS = VLEN / LANES;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, flush, out_ready, out_valid;
  logic [4:0] opcode, rs, rt, rd;
  logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
  logic [3:0] ALUOperation;
  logic [4:0] out_wreg;
  logic [2:0] elem_idx;
  logic       out_last, err_illegal;

  always #5 clk = ~clk;

  vector_control_sequencer #(
    .OPCODE_W(5), .REG_W(5), .VLEN(VLEN), .LANES(LANES), .ALUOP_W(4)
  ) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .rs_i(rs), .rt_i(rt), .rd_i(rd), .flush_i(flush),
    .out_ready_i(out_ready), .out_valid_o(out_valid),
    .RegDst_o(RegDst), .ALUSrc_o(ALUSrc), .MemtoReg_o(MemtoReg), .RegWrite_o(RegWrite),
    .MemRead_o(MemRead), .MemWrite_o(MemWrite), .Branch_o(Branch), .Jump_o(Jump),
    .ALUOperation_o(ALUOperation), .out_wreg_o(out_wreg), .elem_idx_o(elem_idx),
    .out_last_o(out_last), .err_illegal_o(err_illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control word {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALU[3:0]}
  function automatic void ref_decode(input logic [4:0] op, output logic [11:0] bits,
                                     output int beats, output bit legal);
    logic [4:0] s;
    s     = op;
    beats = 1;
    legal = 1'b1;
    case (op)
      5'b10100: begin s = 5'b00001; beats = NBEATS; end
      5'b10101: begin s = 5'b00101; beats = NBEATS; end
      5'b10110: begin s = 5'b01101; beats = NBEATS; end
      5'b10111: begin s = 5'b01111; beats = NBEATS; end
      default: ;
    endcase
    case (s)
      5'b00001: bits = {8'b1001_0000, 4'b0001};
      5'b10011: bits = {8'b0101_0000, 4'b0001};
      5'b00011: bits = {8'b0101_0000, 4'b1000};
      5'b10010: bits = {8'b1001_0000, 4'b1000};
      5'b00101: bits = {8'b1001_0000, 4'b0010};
      5'b01100: bits = {8'b0000_0010, 4'b0011};
      5'b01101: bits = {8'b0111_1000, 4'b0001};
      5'b01111: bits = {8'b0100_0100, 4'b0001};
      5'b01011: bits = {8'b1000_0000, 4'b0011};
      default: begin bits = '0; legal = 1'b0; beats = 1; end
    endcase
  endfunction

  // Model: the instruction currently on the outputs and which beat it is on.
  bit         m_v   = 1'b0;
  bit         m_rst = 1'b1;
  logic [4:0] m_op, m_rs, m_rt, m_rd;
  int         m_beat;

  task automatic step(input bit rst_in, input bit iv, input logic [4:0] op,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input bit fl, input bit ordy);
    logic [11:0] bits, obs_bits;
    int          beats;
    bit          legal, last, haz, exp_rdy;
    logic [4:0]  wreg;
    @(negedge clk);
    reset = rst_in; in_valid = iv; opcode = op; rs = a; rt = b; rd = d;
    flush = fl; out_ready = ordy;
    #1;
    bits = '0; beats = 1; legal = 1'b1; last = 1'b0; wreg = '0;
    if (m_v) begin
      ref_decode(m_op, bits, beats, legal);
      last = (m_beat == beats - 1);
      wreg = bits[11] ? m_rd : m_rt;
    end
    obs_bits = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOperation};
    check_val("out_valid", out_valid, m_v);
    if (m_v) begin
      check_val("ctrl", obs_bits, bits);
      check_val("out_wreg", out_wreg, wreg);
      check_val("elem_idx", elem_idx, m_beat * LANES);
      check_val("out_last", out_last, last);
      check_val("err_illegal", err_illegal, !legal);
    end else if (m_rst) begin
      check_val("reset_outputs", {obs_bits, out_wreg, elem_idx, out_last, err_illegal}, '0);
    end
    haz = iv && m_v && ordy && last && bits[7] && (wreg != 0) && (wreg == a || wreg == b);
    exp_rdy = !rst_in && !fl && !haz && (!m_v || (ordy && last));
    check_val("in_ready", in_ready, exp_rdy);

    m_rst = rst_in;
    if (rst_in || fl) m_v = 1'b0;
    else if (iv && exp_rdy) begin
      m_v = 1'b1; m_op = op; m_rs = a; m_rt = b; m_rd = d; m_beat = 0;
    end else if (m_v && ordy) begin
      if (last) m_v = 1'b0;
      else m_beat++;
    end
  endtask

  logic [4:0] legal_ops [13] = '{5'b00001, 5'b10011, 5'b00011, 5'b10010, 5'b00101,
                                 5'b01100, 5'b01101, 5'b01111, 5'b01011,
                                 5'b10100, 5'b10101, 5'b10110, 5'b10111};

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; rs = '0; rt = '0; rd = '0;
    flush = 1'b0; out_ready = 1'b0;

    step(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1);

    // Directed: ADD/XOR back to back, VADD run, LW load-use with rt=5 then rt=0.
    step(0, 1, 5'b00001, 5'd1, 5'd2, 5'd3, 0, 1);
    step(0, 1, 5'b00101, 5'd1, 5'd2, 5'd4, 0, 1);
    step(0, 1, 5'b10100, 5'd1, 5'd2, 5'd6, 0, 1);
    for (int i = 0; i < NBEATS; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1);
    step(0, 1, 5'b01101, 5'd1, 5'd5, 5'd0, 0, 1);
    step(0, 1, 5'b00001, 5'd5, 5'd1, 5'd2, 0, 1);
    step(0, 1, 5'b00001, 5'd5, 5'd1, 5'd2, 0, 1);
    step(0, 1, 5'b01101, 5'd1, 5'd0, 5'd0, 0, 1);
    step(0, 1, 5'b00001, 5'd0, 5'd1, 5'd2, 0, 1);
    // Illegal opcode, then VXOR flushed mid-run, then reset mid-vector.
    step(0, 1, 5'b11111, 5'd1, 5'd2, 5'd3, 0, 1);
    step(0, 1, 5'b10101, 5'd1, 5'd2, 5'd3, 0, 1);
    step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1);
    step(0, 1, 5'b00001, 5'd1, 5'd2, 5'd3, 1, 1);
    step(0, 1, 5'b00101, 5'd1, 5'd2, 5'd3, 0, 1);
    step(0, 1, 5'b10110, 5'd1, 5'd2, 5'd3, 0, 1);
    step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1);
    step(1, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1);
    step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1);

    for (int ph = 0; ph < 8; ph++) begin
      int pv, pr;
      pv = $urandom_range(40, 100);
      pr = $urandom_range(30, 100);
      for (int i = 0; i < 500; i++) begin
        logic [4:0] op;
        bit         rst_r, fl_r;
        op    = ($urandom_range(0, 5) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 12)];
        rst_r = ($urandom_range(0, 249) == 0);
        fl_r  = ($urandom_range(0, 49) == 0);
        step(rst_r, ($urandom_range(0, 99) < pv), op,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             fl_r, ($urandom_range(0, 99) < pr));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
